// File: rtl/fan_speed_ctrl.sv
// Fan speed controller: hysteretic temperature-to-target law feeding a rate-limited speed ramp.
// Define FAN_KICKSTART_EN to add a full-speed kick-start phase when the fan spins up from off.
`timescale 1ns/1ps
module fan_speed_ctrl #(
  parameter int T_LOW       = 25,
  parameter int T_HIGH      = 40,
  parameter int GAIN_SHIFT  = 4,
  parameter int HYST        = 2,
  parameter int MIN_SPEED   = 32,
  parameter int STEP        = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int KICK_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  input  logic       override_en,
  input  logic [7:0] override_speed,
  output logic [7:0] speed,
  output logic       fan_on,
  output logic       at_target
);

  localparam logic [7:0]        T_LOW_B  = 8'(T_LOW);
  localparam logic [7:0]        T_HIGH_B = 8'(T_HIGH);
  localparam logic signed [8:0] T_OFF    = 9'(T_LOW - HYST);
  localparam logic [7:0]        MIN_B    = 8'(MIN_SPEED);
  localparam logic [8:0]        STEP_B   = 9'(STEP);
  localparam int                CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_RAMP,
    S_HOLD
`ifdef FAN_KICKSTART_EN
    , S_KICK
`endif
  } state_t;

  state_t          r_state, w_state_nxt, w_follow;
  logic [7:0]      r_speed, w_speed_nxt;
  logic [7:0]      r_target, w_target_nxt;
  logic [7:0]      r_temp;
  logic            r_fan_on;
  logic            r_at_target;
  logic [CW-1:0]   r_cnt;
  logic            w_tick;
  logic [7:0]      w_diff, w_prop, w_ramp, w_stepped;
  logic [15:0]     w_shift;
  logic [8:0]      w_up;

`ifdef FAN_KICKSTART_EN
  localparam int            KW        = $clog2(KICK_CYCLES + 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_CYCLES - 1);
  logic [KW-1:0] r_kick_cnt, w_kick_nxt;
`endif

  assign w_tick    = (r_cnt == CNT_LAST);
  assign speed     = r_speed;
  assign fan_on    = r_fan_on;
  assign at_target = r_at_target;

  // Target law works on the sample registered at temp_valid, so it lags that strobe by one clock.
  always_comb begin
    w_diff  = (r_temp > T_LOW_B) ? (r_temp - T_LOW_B) : 8'd0;
    w_shift = {8'd0, w_diff} << GAIN_SHIFT;
    w_prop  = (w_shift > 16'd255) ? 8'hFF : w_shift[7:0];
    if (w_prop < MIN_B) w_prop = MIN_B;
    if (override_en)             w_target_nxt = override_speed;
    else if (!r_fan_on)          w_target_nxt = 8'd0;
    else if (r_temp >= T_HIGH_B) w_target_nxt = 8'hFF;
    else                         w_target_nxt = w_prop;
  end

  // One ramp step toward the target, computed at 9 bits so it cannot wrap.
  always_comb begin
    w_up   = {1'b0, r_speed} + STEP_B;
    w_ramp = r_speed;
    if (r_speed < r_target)
      w_ramp = (w_up >= {1'b0, r_target}) ? r_target : w_up[7:0];
    else if (r_speed > r_target)
      w_ramp = ({1'b0, r_speed} <= ({1'b0, r_target} + STEP_B)) ? r_target
                                                                 : (r_speed - STEP_B[7:0]);
    w_stepped = w_tick ? w_ramp : r_speed;
    w_follow  = (w_stepped != r_target) ? S_RAMP :
                (r_target == 8'd0)      ? S_OFF  : S_HOLD;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
`ifdef FAN_KICKSTART_EN
    w_kick_nxt  = r_kick_cnt;
`endif
    case (r_state)
`ifdef FAN_KICKSTART_EN
      S_KICK: begin
        if (r_target == 8'd0) begin
          w_state_nxt = S_OFF;
          w_speed_nxt = 8'd0;
        end else begin
          w_speed_nxt = 8'hFF;
          if (r_kick_cnt == KICK_LAST) w_state_nxt = S_RAMP;
          else                         w_kick_nxt  = r_kick_cnt + 1'b1;
        end
      end
      S_OFF: begin
        if (r_target != 8'd0) begin
          w_state_nxt = S_KICK;
          w_speed_nxt = 8'hFF;
          w_kick_nxt  = '0;
        end else begin
          w_state_nxt = w_follow;
          w_speed_nxt = w_stepped;
        end
      end
`endif
      default: begin
        w_state_nxt = w_follow;
        w_speed_nxt = w_stepped;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= S_OFF;
      r_speed <= 8'd0;
`ifdef FAN_KICKSTART_EN
      r_kick_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
`ifdef FAN_KICKSTART_EN
      r_kick_cnt <= w_kick_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_cnt       <= '0;
      r_temp      <= 8'd0;
      r_fan_on    <= 1'b0;
      r_target    <= 8'd0;
      r_at_target <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : (r_cnt + 1'b1);
      if (temp_valid) begin
        r_temp <= temp;
        if (temp > T_LOW_B)                     r_fan_on <= 1'b1;
        else if ($signed({1'b0, temp}) < T_OFF) r_fan_on <= 1'b0;
      end
      r_target    <= w_target_nxt;
      r_at_target <= (w_speed_nxt == w_target_nxt);
    end
  end

endmodule
